// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter that grants the shared slave bus for whole cycles and alternates under contention.
// Define WB_ARB_TIMEOUT_EN to force-terminate strobes that wait TIMEOUT cycles for an ack.
module wb_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_m0_cyc,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data,
    input  logic [DW/8-1:0] i_m0_sel,
    output logic            o_m0_ack,
    output logic            o_m0_stall,
    output logic [DW-1:0]   o_m0_data,

    input  logic            i_m1_cyc,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data,
    input  logic [DW/8-1:0] i_m1_sel,
    output logic            o_m1_ack,
    output logic            o_m1_stall,
    output logic [DW-1:0]   o_m1_data,

    output logic            o_s_cyc,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data,
    output logic [DW/8-1:0] o_s_sel,
    input  logic            i_s_ack,
    input  logic            i_s_stall,
    input  logic [DW-1:0]   i_s_data,

    output logic [1:0]      o_grant,
    output logic            o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;

    logic            m_cyc;
    logic            m_stb;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [DW/8-1:0] m_sel;

    logic            resp_ack;
    logic            resp_stall;
    logic [DW-1:0]   resp_data;
    logic            timeout_hit;

    // Passing through IDLE between every grant keeps ownership changes clean and makes alternation fair.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!i_m0_cyc) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (!i_m1_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_d = {state_d == GNT1, state_d == GNT0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign o_grant = grant_q;

    always_comb begin
        m_cyc  = i_m0_cyc;
        m_stb  = i_m0_stb;
        m_we   = i_m0_we;
        m_addr = i_m0_addr;
        m_data = i_m0_data;
        m_sel  = i_m0_sel;
        if (state_q == GNT1) begin
            m_cyc  = i_m1_cyc;
            m_stb  = i_m1_stb;
            m_we   = i_m1_we;
            m_addr = i_m1_addr;
            m_data = i_m1_data;
            m_sel  = i_m1_sel;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // The counter value is the number of earlier stalled cycles, so the forced ack lands in stalled cycle TIMEOUT.
    always_comb begin
        tmo_cnt_d   = '0;
        timeout_hit = 1'b0;
        if (state_q != IDLE && m_cyc && m_stb && !i_s_ack) begin
            if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_param;

    assign timeout_hit          = 1'b0;
    assign unused_timeout_param = (TIMEOUT != 0);
`endif

    always_comb begin
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_s_sel    = '0;
        resp_ack   = 1'b0;
        resp_stall = 1'b1;
        resp_data  = '0;
        o_timeout  = 1'b0;
        if (state_q != IDLE) begin
            o_s_cyc    = m_cyc;
            o_s_stb    = m_stb;
            o_s_we     = m_we;
            o_s_addr   = m_addr;
            o_s_data   = m_data;
            o_s_sel    = m_sel;
            resp_ack   = i_s_ack & m_cyc;
            resp_stall = i_s_stall;
            resp_data  = i_s_data;
            if (timeout_hit) begin
                o_s_cyc   = 1'b0;
                o_s_stb   = 1'b0;
                resp_ack  = 1'b1;
                resp_data = '1;
                o_timeout = 1'b1;
            end
        end
    end

    // The master without the grant is held off with a permanent stall.
    always_comb begin
        o_m0_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m0_data  = '0;
        o_m1_ack   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_data  = '0;
        if (state_q == GNT0) begin
            o_m0_ack   = resp_ack;
            o_m0_stall = resp_stall;
            o_m0_data  = resp_data;
        end else if (state_q == GNT1) begin
            o_m1_ack   = resp_ack;
            o_m1_stall = resp_stall;
            o_m1_data  = resp_data;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: cycle vector table through a scoreboard queue, plus reset and timeout sequences.
module tb_wb_master_arbiter;

    localparam logic [31:0] M0_ADDR = 32'h0001_0000;
    localparam logic [31:0] M1_ADDR = 32'h0002_0040;
    localparam logic [31:0] M0_WDAT = 32'h0000_00A0;
    localparam logic [31:0] M1_WDAT = 32'h0000_00B1;
    localparam logic [3:0]  M0_SEL  = 4'hF;
    localparam logic [3:0]  M1_SEL  = 4'h3;

    logic        clk;
    logic        rst_n;
    logic        i_m0_cyc, i_m0_stb, i_m0_we;
    logic [31:0] i_m0_addr, i_m0_data;
    logic [3:0]  i_m0_sel;
    logic        o_m0_ack, o_m0_stall;
    logic [31:0] o_m0_data;
    logic        i_m1_cyc, i_m1_stb, i_m1_we;
    logic [31:0] i_m1_addr, i_m1_data;
    logic [3:0]  i_m1_sel;
    logic        o_m1_ack, o_m1_stall;
    logic [31:0] o_m1_data;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [31:0] o_s_addr, o_s_data;
    logic [3:0]  o_s_sel;
    logic        i_s_ack, i_s_stall;
    logic [31:0] i_s_data;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        logic        m0c, m0s, m1c, m1s, ack;
        logic [31:0] sd;
        logic [1:0]  eg;
        logic        esc, ess, e0a, e0s;
        logic [31:0] e0d;
        logic        e1a, e1s;
        logic [31:0] e1d;
    } vec_t;

    vec_t vecs[30];
    vec_t exp_q[$];

    wb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
        .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_data(o_m0_data),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
        .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_data(o_m1_data),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
        .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_data(i_s_data),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic m0c, m0s, m1c, m1s, ack, input logic [31:0] sd,
                               input logic [1:0] eg, input logic esc, ess, e0a, e0s,
                               input logic [31:0] e0d, input logic e1a, e1s, input logic [31:0] e1d);
        vec_t r;
        r.m0c = m0c; r.m0s = m0s; r.m1c = m1c; r.m1s = m1s; r.ack = ack; r.sd = sd;
        r.eg = eg; r.esc = esc; r.ess = ess; r.e0a = e0a; r.e0s = e0s; r.e0d = e0d;
        r.e1a = e1a; r.e1s = e1s; r.e1d = e1d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " grant"}, 32'(o_grant), 32'h0);
        chk({tag, " s_cyc"}, 32'(o_s_cyc), 32'h0);
        chk({tag, " s_stb"}, 32'(o_s_stb), 32'h0);
        chk({tag, " s_addr"}, o_s_addr, 32'h0);
        chk({tag, " m0_ack"}, 32'(o_m0_ack), 32'h0);
        chk({tag, " m0_stall"}, 32'(o_m0_stall), 32'h1);
        chk({tag, " m1_stall"}, 32'(o_m1_stall), 32'h1);
        chk({tag, " m1_data"}, o_m1_data, 32'h0);
        chk({tag, " timeout"}, 32'(o_timeout), 32'h0);
    endtask

    task automatic idle_inputs();
        i_m0_cyc = 0; i_m0_stb = 0; i_m1_cyc = 0; i_m1_stb = 0;
        i_s_ack = 0; i_s_stall = 0; i_s_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t t);
        @(posedge clk);
        #1;
        i_m0_cyc = t.m0c; i_m0_stb = t.m0s;
        i_m1_cyc = t.m1c; i_m1_stb = t.m1s;
        i_s_ack = t.ack; i_s_stall = 1'b0; i_s_data = t.sd;
        exp_q.push_back(t);
    endtask

    task automatic check_output(input int idx);
        vec_t e;
        string p;
        e = exp_q.pop_front();
        p = $sformatf("row%0d", idx);
        chk({p, " grant"}, 32'(o_grant), 32'(e.eg));
        chk({p, " s_cyc"}, 32'(o_s_cyc), 32'(e.esc));
        chk({p, " s_stb"}, 32'(o_s_stb), 32'(e.ess));
        chk({p, " s_addr"}, o_s_addr, (e.eg == 2'b01) ? M0_ADDR : (e.eg == 2'b10) ? M1_ADDR : 32'h0);
        chk({p, " s_wdat"}, o_s_data, (e.eg == 2'b01) ? M0_WDAT : (e.eg == 2'b10) ? M1_WDAT : 32'h0);
        chk({p, " s_we"}, 32'(o_s_we), 32'(e.eg == 2'b10));
        chk({p, " s_sel"}, 32'(o_s_sel), (e.eg == 2'b01) ? 32'(M0_SEL) : (e.eg == 2'b10) ? 32'(M1_SEL) : 32'h0);
        chk({p, " m0_ack"}, 32'(o_m0_ack), 32'(e.e0a));
        chk({p, " m0_stall"}, 32'(o_m0_stall), 32'(e.e0s));
        chk({p, " m0_data"}, o_m0_data, e.e0d);
        chk({p, " m1_ack"}, 32'(o_m1_ack), 32'(e.e1a));
        chk({p, " m1_stall"}, 32'(o_m1_stall), 32'(e.e1s));
        chk({p, " m1_data"}, o_m1_data, e.e1d);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(i);
        end
    endtask

    initial begin
        int pulses;
        int acks;

        i_m0_we = 1'b0; i_m0_addr = M0_ADDR; i_m0_data = M0_WDAT; i_m0_sel = M0_SEL;
        i_m1_we = 1'b1; i_m1_addr = M1_ADDR; i_m1_data = M1_WDAT; i_m1_sel = M1_SEL;
        idle_inputs();
        rst_n = 1'b0;

        // Single m0 read, ack two cycles after the strobe, late ack after cyc drops is dropped.
        vecs[0]  = v(1,1,0,0,0, 32'h0,         2'b00, 0,0, 0,1,32'h0,         0,1,32'h0);
        vecs[1]  = v(1,1,0,0,0, 32'h0BAD_0000, 2'b01, 1,1, 0,0,32'h0BAD_0000, 0,1,32'h0);
        vecs[2]  = v(1,0,0,0,0, 32'h0,         2'b01, 1,0, 0,0,32'h0,         0,1,32'h0);
        vecs[3]  = v(1,0,0,0,1, 32'h1234_5678, 2'b01, 1,0, 1,0,32'h1234_5678, 0,1,32'h0);
        vecs[4]  = v(0,0,0,0,1, 32'h0000_0055, 2'b01, 0,0, 0,0,32'h0000_0055, 0,1,32'h0);
        vecs[5]  = v(0,0,0,0,0, 32'h0,         2'b00, 0,0, 0,1,32'h0,         0,1,32'h0);
        // Continuous contention: m0, m1, m0, m1 with an idle cycle between grants.
        vecs[6]  = v(1,1,1,1,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[7]  = v(1,1,1,1,1, 32'hA1, 2'b01, 1,1, 1,0,32'hA1, 0,1,32'h0);
        vecs[8]  = v(0,0,1,1,0, 32'h0,  2'b01, 0,0, 0,0,32'h0,  0,1,32'h0);
        vecs[9]  = v(1,1,1,1,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[10] = v(1,1,1,1,1, 32'hA2, 2'b10, 1,1, 0,1,32'h0,  1,0,32'hA2);
        vecs[11] = v(1,1,0,0,0, 32'h0,  2'b10, 0,0, 0,1,32'h0,  0,0,32'h0);
        vecs[12] = v(1,1,1,1,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[13] = v(1,1,1,1,1, 32'hA3, 2'b01, 1,1, 1,0,32'hA3, 0,1,32'h0);
        vecs[14] = v(0,0,1,1,0, 32'h0,  2'b01, 0,0, 0,0,32'h0,  0,1,32'h0);
        vecs[15] = v(1,1,1,1,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[16] = v(1,1,1,1,1, 32'hA4, 2'b10, 1,1, 0,1,32'h0,  1,0,32'hA4);
        vecs[17] = v(0,0,0,0,0, 32'h0,  2'b10, 0,0, 0,1,32'h0,  0,0,32'h0);
        vecs[18] = v(0,0,0,0,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        // m1 four-strobe burst while m0 waits.
        vecs[19] = v(0,0,1,1,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[20] = v(1,1,1,1,0, 32'h0,  2'b10, 1,1, 0,1,32'h0,  0,0,32'h0);
        vecs[21] = v(1,1,1,1,1, 32'hB1, 2'b10, 1,1, 0,1,32'h0,  1,0,32'hB1);
        vecs[22] = v(1,1,1,1,1, 32'hB2, 2'b10, 1,1, 0,1,32'h0,  1,0,32'hB2);
        vecs[23] = v(1,1,1,1,1, 32'hB3, 2'b10, 1,1, 0,1,32'h0,  1,0,32'hB3);
        vecs[24] = v(1,1,1,0,1, 32'hB4, 2'b10, 1,0, 0,1,32'h0,  1,0,32'hB4);
        vecs[25] = v(1,1,0,0,0, 32'h0,  2'b10, 0,0, 0,1,32'h0,  0,0,32'h0);
        vecs[26] = v(1,1,0,0,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);
        vecs[27] = v(1,1,0,0,0, 32'h0,  2'b01, 1,1, 0,0,32'h0,  0,1,32'h0);
        vecs[28] = v(0,0,0,0,0, 32'h0,  2'b01, 0,0, 0,0,32'h0,  0,1,32'h0);
        vecs[29] = v(0,0,0,0,0, 32'h0,  2'b00, 0,0, 0,1,32'h0,  0,1,32'h0);

        do_reset();
        run_rows(0, 5);
        do_reset();
        run_rows(6, 18);
        do_reset();
        run_rows(19, 29);

        // Asynchronous reset in the middle of a stalled transfer, then a late slave ack.
        do_reset();
        @(posedge clk); #1;
        i_m0_cyc = 1; i_m0_stb = 1; i_s_stall = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst granted", 32'(o_grant), 32'h1);
        chk("midrst s_cyc", 32'(o_s_cyc), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst async");
        idle_inputs();
        i_s_ack = 1; i_s_data = 32'h0000_CAFE;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("late ack m0_ack", 32'(o_m0_ack), 32'h0);
        chk("late ack m0_data", o_m0_data, 32'h0);
        chk("late ack grant", 32'(o_grant), 32'h0);
        idle_inputs();

        // Slave never acks a stalled m0 strobe.
        do_reset();
        @(posedge clk); #1;
        i_m0_cyc = 1; i_m0_stb = 1; i_s_stall = 1;
        @(negedge clk);
        chk("tmo idle grant", 32'(o_grant), 32'h0);
        pulses = 0;
        acks = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (o_timeout) pulses++;
            if (k < 8) begin
                chk($sformatf("tmo c%0d m0_ack", k), 32'(o_m0_ack), 32'h0);
                chk($sformatf("tmo c%0d s_cyc", k), 32'(o_s_cyc), 32'h1);
            end else begin
                chk("tmo fire m0_ack", 32'(o_m0_ack), 32'h1);
                chk("tmo fire m0_data", o_m0_data, 32'hFFFF_FFFF);
                chk("tmo fire s_cyc", 32'(o_s_cyc), 32'h0);
                chk("tmo fire s_stb", 32'(o_s_stb), 32'h0);
                chk("tmo fire timeout", 32'(o_timeout), 32'h1);
            end
        end
        @(posedge clk); #1;
        i_m0_cyc = 0; i_m0_stb = 0;
        @(negedge clk);
        if (o_timeout) pulses++;
        chk("tmo after grant held", 32'(o_grant), 32'h1);
        chk("tmo after m0_ack", 32'(o_m0_ack), 32'h0);
        chk("tmo pulse count", 32'(pulses), 32'h1);
`else
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (o_timeout) pulses++;
            if (o_m0_ack) acks++;
        end
        chk("stall acks", 32'(acks), 32'h0);
        chk("stall timeouts", 32'(pulses), 32'h0);
        chk("stall grant held", 32'(o_grant), 32'h1);
        chk("stall s_cyc", 32'(o_s_cyc), 32'h1);
        @(posedge clk); #1;
        i_m0_cyc = 0; i_m0_stb = 0;
`endif
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("final idle grant", 32'(o_grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter between bus masters and the single shared slave bus that feeds the slave address decoder. Port 0 carries the PicoRV32 Wishbone master; port 1 carries a secondary master such as a UART boot loader or DMA engine. It grants the shared bus for whole cycles (`cyc` held), alternates fairly under contention and optionally terminates stalled transfers.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; select width is `DW/8`.
- `TIMEOUT`, 255, cycles a strobe may wait for ack before forced termination (only with the macro); legal range 2..65535.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we` in 1 each: master 0 control.
- `i_m0_addr` in AW, `i_m0_data` in DW, `i_m0_sel` in DW/8: master 0 request.
- `o_m0_ack` out 1, `o_m0_stall` out 1, `o_m0_data` out DW: master 0 response.
- `i_m1_*` / `o_m1_*`: identical set for master 1.
- `o_s_cyc`, `o_s_stb`, `o_s_we` out 1 each; `o_s_addr` out AW; `o_s_data` out DW; `o_s_sel` out DW/8: shared slave request.
- `i_s_ack` in 1, `i_s_stall` in 1, `i_s_data` in DW: shared slave response.
- `o_grant` out 2: one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.
- `o_timeout` out 1: one-cycle pulse on forced termination (tied 0 without the macro).

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state: IDLE, with `last` = 1 so m0 wins the first contention.
- IDLE: if exactly one `i_mX_cyc` is high, go to GNTX. If both are high, grant the master that is not `last`. Record the granted index in `last`.
- GNTX: slave outputs = master X inputs, passed through combinationally. `o_mX_ack` = `i_s_ack`; `o_mX_stall` = `i_s_stall`; `o_mX_data` = `i_s_data`.
- Non-granted master: `ack` = 0, `stall` = 1, `data` = 0. Its `stb` never reaches the slave.
- GNTX → IDLE when `i_mX_cyc` = 0. The bus stays in IDLE for exactly one cycle before any new grant. Grant is never revoked while `cyc` is high, including multi-strobe pipelined bursts.
- In IDLE all slave outputs are 0. Both masters see `ack` = 0, `stall` = 1.
- Ack arriving while the granted master has `cyc` low is discarded.
- Reset asserted mid-transfer: immediately IDLE, all outputs 0, `o_m*_stall` = 1. An in-flight slave ack after reset release is discarded.

## Timing
- Grant latency: `cyc` asserted in cycle N is seen on `o_s_cyc` in cycle N+1. The request path adds no further latency.
- Response path (ack/stall/data) is combinational: zero added cycles.
- Reset values: `o_s_*` = 0, `o_grant` = 00, `o_m0/1_ack` = 0, `o_m0/1_stall` = 1, `o_m0/1_data` = 0, `o_timeout` = 0.
- Under continuous contention the owners alternate m0, m1, m0, … with one IDLE cycle between grants.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in GNTX while `o_s_stb` = 1 and `i_s_ack` = 0. It clears on ack, on `stb` low or on leaving GNTX.
  - When the counter reaches `TIMEOUT`, for that one cycle: `o_mX_ack` = 1, `o_mX_data` = all ones, `o_s_cyc` = `o_s_stb` = 0, `o_timeout` = 1. The counter then clears.
  - The grant is held until the master drops `cyc`.
- Macro not defined: no counter, `o_timeout` = 0, and a stalled slave blocks the bus indefinitely.

## Test plan
- Reset, then m0 single read at addr 0x0001_0000 with slave ack 2 cycles later → `o_s_cyc` rises 1 cycle after `i_m0_cyc`; `o_m0_data` = slave data; `o_grant` = 01.
- m0 and m1 assert `cyc` in the same cycle, 4 repetitions → grants m0, m1, m0, m1; one IDLE cycle between each; loser sees `stall` = 1, `ack` = 0.
- m1 holds `cyc` over a 4-strobe burst while m0 requests → m0 is not granted until m1 drops `cyc`; all 4 acks go to m1 only.
- `rst_n` pulled low mid-transfer with the slave ack arriving after release → all outputs return to reset values asynchronously; the late ack is not forwarded.
- `WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 8, slave never acks → `o_m0_ack` = 1 with data 0xFFFF_FFFF in the 8th stalled cycle, `o_timeout` pulses once, `o_s_cyc` = 0 for that cycle.
- Without the macro, same stimulus → no ack after 1000 cycles, `o_timeout` stays 0.
